pipe_stage_multi: RTL and testbench

PIPE_STAGE_MULTI -- requirements
Module: pipe_stage_multi

---
 rtl/pipe_stage_multi_pkg.sv | 20 ++
 rtl/pipe_stage_entry.sv | 36 +++
 rtl/pipe_stage_multi.sv | 120 ++++++++++++
 tb/tb_pipe_stage_multi.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_multi_pkg.sv
// rtl/pipe_stage_multi_pkg.sv - shared lane widths, stage lengths and NOP constant
package pipe_stage_multi_pkg;

  localparam int LANE_WIDTH     = 96;
  localparam int MAX_LANES      = 4;
  localparam int PIPE_DEPTH_LEN = 2;  // bundles held: head + skid
  localparam int PIPE_OCC_LEN   = 2;  // bits needed to count 0..PIPE_DEPTH_LEN

  localparam logic [31:0]           NOP_INSN = 32'h00000013;
  localparam logic [LANE_WIDTH-1:0] LANE_NOP = {64'h0, NOP_INSN};

  // What the head register does at the next edge
  typedef enum logic [1:0] {
    HEAD_HOLD,
    HEAD_LOAD_IN,
    HEAD_LOAD_SKID,
    HEAD_CLEAR
  } headAction_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// rtl/pipe_stage_entry.sv - one bundle register with per-lane valid, load, clear and lane kill
module pipe_stage_entry #(
  parameter int                     LANES     = 2,
  parameter int                     WIDTH     = 96,
  parameter logic [LANES*WIDTH-1:0] RST_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic [LANES-1:0]       loadValid,
  input  logic [LANES*WIDTH-1:0] loadData,
  input  logic [LANES-1:0]       killMask,
  output logic [LANES-1:0]       valid,
  output logic [LANES*WIDTH-1:0] data
);

  // Clear beats load beats kill; killed lanes fall back to their reset slice
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= '0;
      data  <= RST_VALUE;
    end else if (load) begin
      valid <= loadValid;
      data  <= loadData;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (killMask[l]) begin
          valid[l]                <= 1'b0;
          data[l*WIDTH +: WIDTH]  <= RST_VALUE[l*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_stage_multi.sv
// rtl/pipe_stage_multi.sv - two-deep multi-lane bundle pipeline stage with kill, stall and flush
module pipe_stage_multi
  import pipe_stage_multi_pkg::*;
#(
  parameter int                     LANES     = 2,
  parameter int                     WIDTH     = LANE_WIDTH,
  parameter logic [LANES*WIDTH-1:0] RST_VALUE = {LANES{LANE_NOP}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*WIDTH-1:0]  in_data,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*WIDTH-1:0]  out_data,
  input  logic                    out_ready,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [LANES-1:0]        kill,
  output logic [PIPE_OCC_LEN-1:0] occupancy
);

  localparam logic [PIPE_OCC_LEN-1:0] OCC_EMPTY = 2'd0;
  localparam logic [PIPE_OCC_LEN-1:0] OCC_ONE   = 2'd1;
  localparam logic [PIPE_OCC_LEN-1:0] OCC_FULL  = 2'd2;

  logic [PIPE_OCC_LEN-1:0] occQ, occD;
  logic [LANES-1:0]        headValid, skidValid, headKill, headLoadValid;
  logic [LANES*WIDTH-1:0]  headData, skidData, headLoadData;
  logic                    push, pop, headDead, removeHead;
  logic                    skidLoad, skidClear;
  headAction_e             headAct;

  // rst_n is active-high here; ready never looks at out_ready
  assign in_ready   = !rst_n && !stall && (occQ != OCC_FULL);
  assign push       = in_ready && (|in_valid) && !flush;
  assign pop        = (occQ != OCC_EMPTY) && out_ready && !stall && !flush;
  assign headKill   = ((occQ != OCC_EMPTY) && !flush) ? kill : '0;
  assign headDead   = (occQ != OCC_EMPTY) && ((headValid & ~kill) == '0);
  // A fully killed head and a pop in the same edge retire only the head
  assign removeHead = (pop || headDead) && !flush;

  // Decide head/skid movement and the next occupancy
  always_comb begin
    headAct   = HEAD_HOLD;
    skidLoad  = 1'b0;
    skidClear = 1'b0;
    occD      = occQ;
    if (flush) begin
      headAct   = HEAD_CLEAR;
      skidClear = 1'b1;
      occD      = OCC_EMPTY;
    end else begin
      case (occQ)
        OCC_EMPTY: begin
          if (push) begin
            headAct = HEAD_LOAD_IN;
            occD    = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (removeHead && push) begin
            headAct = HEAD_LOAD_IN;
          end else if (removeHead) begin
            headAct = HEAD_CLEAR;
            occD    = OCC_EMPTY;
          end else if (push) begin
            skidLoad = 1'b1;
            occD     = OCC_FULL;
          end
        end
        default: begin
          if (removeHead) begin
            headAct   = HEAD_LOAD_SKID;
            skidClear = 1'b1;
            occD      = OCC_ONE;
          end
        end
      endcase
    end
  end

  assign headLoadValid = (headAct == HEAD_LOAD_SKID) ? skidValid : in_valid;
  assign headLoadData  = (headAct == HEAD_LOAD_SKID) ? skidData  : in_data;

  pipe_stage_entry #(.LANES(LANES), .WIDTH(WIDTH), .RST_VALUE(RST_VALUE)) uHead (
    .clk       (clk),
    .rst       (rst_n),
    .load      ((headAct == HEAD_LOAD_IN) || (headAct == HEAD_LOAD_SKID)),
    .clear     (headAct == HEAD_CLEAR),
    .loadValid (headLoadValid),
    .loadData  (headLoadData),
    .killMask  (headKill),
    .valid     (headValid),
    .data      (headData)
  );

  pipe_stage_entry #(.LANES(LANES), .WIDTH(WIDTH), .RST_VALUE(RST_VALUE)) uSkid (
    .clk       (clk),
    .rst       (rst_n),
    .load      (skidLoad),
    .clear     (skidClear),
    .loadValid (in_valid),
    .loadData  (in_data),
    .killMask  ('0),
    .valid     (skidValid),
    .data      (skidData)
  );

  // Registered bundle count
  always_ff @(posedge clk) begin
    if (rst_n) occQ <= OCC_EMPTY;
    else       occQ <= occD;
  end

  assign occupancy = occQ;
  assign out_valid = headValid;
  assign out_data  = headData;

endmodule

// File: tb/tb_pipe_stage_multi.sv
// tb/tb_pipe_stage_multi.sv - randomized and directed bench for pipe_stage_multi
module tb_pipe_stage_multi;

  localparam logic [95:0]  NOP_LANE = {64'h0, 32'h00000013};
  localparam logic [191:0] RSTV     = {NOP_LANE, NOP_LANE};

  typedef struct packed {
    logic [1:0]   v;
    logic [191:0] d;
  } bundle_t;

  logic         clk;
  logic         rst_n, stall, flush, out_ready;
  logic [1:0]   in_valid, kill;
  logic [191:0] in_data;
  logic         in_ready;
  logic [1:0]   out_valid;
  logic [191:0] out_data;
  logic [1:0]   occupancy;

  int      vectors = 0;
  int      miscompares = 0;
  bundle_t q[$];

  pipe_stage_multi dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall     (stall),
    .flush     (flush),
    .kill      (kill),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] randData();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference: a FIFO of at most two bundles; kill edits the front, an empty front leaves
  function automatic void modelEdge();
    bundle_t h;
    bit      doPush, rm;
    if (rst_n || flush) begin
      q.delete();
      return;
    end
    doPush = !stall && (q.size() < 2) && (in_valid != 2'b00);
    if (q.size() > 0) begin
      h  = q[0];
      rm = out_ready && !stall;
      for (int l = 0; l < 2; l++) begin
        if (kill[l]) begin
          h.v[l]          = 1'b0;
          h.d[l*96 +: 96] = NOP_LANE;
        end
      end
      q[0] = h;
      if (h.v == 2'b00) rm = 1'b1;
      if (rm) void'(q.pop_front());
    end
    if (doPush) begin
      h.v = in_valid;
      h.d = in_data;
      q.push_back(h);
    end
  endfunction

  function automatic logic expReady();
    return !rst_n && !stall && (q.size() < 2);
  endfunction

  function automatic logic [195:0] expState();
    if (q.size() == 0) return {2'b00, RSTV, 2'b00};
    return {q[0].v, q[0].d, 2'(q.size())};
  endfunction

  task automatic drive(input logic r, input logic st, input logic fl, input logic ordy,
                       input logic [1:0] iv, input logic [1:0] k, input logic [191:0] id);
    @(negedge clk);
    rst_n = r; stall = st; flush = fl; out_ready = ordy;
    in_valid = iv; kill = k; in_data = id;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic emptyStage();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, '0);
    tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, randData());
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      tick();
      vectors++;
      if ({out_valid, out_data, occupancy} !== {2'b00, RSTV, 2'b00}) begin
        miscompares++;
        $display("FAIL reset_state: got %h want %h", {out_valid, out_data, occupancy}, {2'b00, RSTV, 2'b00});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, '0);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [191:0] a, b;
    a = {48{4'hA}};
    b = {48{4'hB}};
    emptyStage();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, a); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, b); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, '0);
    vectors++;
    if ({in_ready, occupancy, out_data} !== {1'b0, 2'd2, a}) begin
      miscompares++;
      $display("FAIL bp_full: got rdy=%b occ=%0d d=%h want rdy=0 occ=2 d=%h", in_ready, occupancy, out_data, a);
    end
    tick();
    vectors++;
    if ({out_valid, out_data, occupancy} !== {2'b11, b, 2'd1}) begin
      miscompares++;
      $display("FAIL bp_second: got %h want %h", {out_valid, out_data, occupancy}, {2'b11, b, 2'd1});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, '0); tick();
    vectors++;
    if ({out_valid, out_data, occupancy} !== {2'b00, RSTV, 2'd0}) begin
      miscompares++;
      $display("FAIL bp_drained: got %h want %h", {out_valid, out_data, occupancy}, {2'b00, RSTV, 2'd0});
    end
  endtask

  task automatic test_streaming();
    logic [191:0] d;
    emptyStage();
    for (int i = 0; i < 100; i++) begin
      d = randData();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, d);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready %0d: got %b want 1", i, in_ready);
      end
      tick();
      vectors++;
      if ({out_valid, out_data, occupancy} !== {2'b11, d, 2'd1}) begin
        miscompares++;
        $display("FAIL stream_out %0d: got %h want %h", i, {out_valid, out_data, occupancy}, {2'b11, d, 2'd1});
      end
    end
  endtask

  task automatic test_kill();
    logic [191:0] x, y;
    x = randData();
    y = randData();
    emptyStage();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, x); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, y); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, '0); tick();
    vectors++;
    if ({out_valid, out_data, occupancy} !== {2'b01, NOP_LANE, x[95:0], 2'd2}) begin
      miscompares++;
      $display("FAIL kill_lane1: got %h want %h", {out_valid, out_data, occupancy}, {2'b01, NOP_LANE, x[95:0], 2'd2});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, '0); tick();
    vectors++;
    if ({out_valid, out_data, occupancy} !== {2'b11, y, 2'd1}) begin
      miscompares++;
      $display("FAIL kill_promote: got %h want %h", {out_valid, out_data, occupancy}, {2'b11, y, 2'd1});
    end
  endtask

  task automatic test_flush_stall();
    emptyStage();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, randData()); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, randData()); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01, randData()); tick();
    vectors++;
    if ({out_valid, out_data, occupancy} !== {2'b00, RSTV, 2'd0}) begin
      miscompares++;
      $display("FAIL flush_stall: got %h want %h", {out_valid, out_data, occupancy}, {2'b00, RSTV, 2'd0});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, '0); tick();
    vectors++;
    if (occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL flush_drop_incoming: got occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_bubble();
    logic [191:0] d;
    d = randData();
    emptyStage();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, d); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, randData());
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bubble_ready: got %b want 1", in_ready);
    end
    tick();
    vectors++;
    if ({out_valid, out_data, occupancy} !== {2'b10, d, 2'd1}) begin
      miscompares++;
      $display("FAIL bubble_hold: got %h want %h", {out_valid, out_data, occupancy}, {2'b10, d, 2'd1});
    end
  endtask

  task automatic test_reset_mid();
    emptyStage();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, randData()); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, randData()); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, randData()); tick();
    vectors++;
    if ({out_valid, out_data, occupancy} !== {2'b00, RSTV, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want %h", {out_valid, out_data, occupancy}, {2'b00, RSTV, 2'd0});
    end
  endtask

  task automatic test_random();
    logic       r, st, fl, ordy;
    logic [1:0] iv, k;
    emptyStage();
    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 199) == 0);
      st   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      iv   = 2'($urandom_range(0, 3));
      k    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive(r, st, fl, ordy, iv, k, randData());
      vectors++;
      if (in_ready !== expReady()) begin
        miscompares++;
        $display("FAIL rand_ready %0d: got %b want %b", i, in_ready, expReady());
      end
      tick();
      vectors++;
      if ({out_valid, out_data, occupancy} !== expState()) begin
        miscompares++;
        $display("FAIL rand_state %0d: got %h want %h", i, {out_valid, out_data, occupancy}, expState());
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 2'b00; kill = 2'b00; in_data = '0;
    test_reset();
    test_backpressure();
    test_streaming();
    test_kill();
    test_flush_stall();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
